// File: rtl/s2p_ctrl_if.sv
// Bus between a bit-serial source / word consumer and the s2p_ctrl capture controller.
// Word handshake: dout moves on any edge where dout_valid and dout_ready are both high; dout is stable while dout_valid=1 and dout_ready=0.
interface s2p_ctrl_if #(
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(WIDTH + 1);

  logic             start;
  logic             abort;
  logic             sin;
  logic             sin_valid;
  logic             dout_ready;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             busy;
  logic [CW-1:0]    bit_cnt;
  logic             overrun;

  modport master (
    output start, abort, sin, sin_valid, dout_ready,
    input  dout, dout_valid, busy, bit_cnt, overrun
  );

  modport slave (
    input  start, abort, sin, sin_valid, dout_ready,
    output dout, dout_valid, busy, bit_cnt, overrun
  );
endinterface

// File: rtl/s2p_ctrl.sv
// Serial-to-parallel capture controller: frame FSM plus bit counter gate a clock-enabled
// shift register, and the finished word is moved into a valid/ready holding register.
module s2p_ctrl #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  s2p_ctrl_if.slave    bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dv_q, dv_d;
  logic             ovr_q, ovr_d;
  logic             shift_en;
  logic             complete;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_en = 1'b0;
    complete = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        // abort wins over a same-cycle final bit, so that bit never reaches the register
        if (bus.abort) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (bus.sin_valid) begin
          shift_en = 1'b1;
          if (cnt_q == LAST) begin
            complete = 1'b1;
            state_d  = IDLE;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    sr_d = sr_q;
    if (shift_en) begin
      sr_d = MSB_FIRST ? {sr_q[WIDTH-2:0], bus.sin} : {bus.sin, sr_q[WIDTH-1:1]};
    end
  end

  // The completing word is taken from sr_d so the final bit lands in dout on the same edge.
  always_comb begin
    dout_d = dout_q;
    dv_d   = dv_q;
    ovr_d  = ovr_q;
    if (complete) begin
      if (!dv_q || bus.dout_ready) begin
        dout_d = sr_d;
        dv_d   = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (dv_q && bus.dout_ready) begin
      dv_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      dout_q  <= '0;
      dv_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      dout_q  <= dout_d;
      dv_q    <= dv_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dv_q;
  assign bus.busy       = (state_q == SHIFT);
  assign bus.bit_cnt    = cnt_q;
  assign bus.overrun    = ovr_q;
endmodule

// File: tb/tb_s2p_ctrl.sv
// Bench for s2p_ctrl: an 8-bit MSB-first and a 4-bit LSB-first instance checked each cycle
// against a frame-level model, plus literal expectations from directed frames.
module tb_s2p_ctrl;
  logic clk;
  logic rst;

  int checks;
  int failures;

  s2p_ctrl_if #(.WIDTH(8)) ifa ();
  s2p_ctrl_if #(.WIDTH(4)) ifb ();

  s2p_ctrl #(.WIDTH(8), .MSB_FIRST(1'b1)) u_a (.clk(clk), .rst(rst), .bus(ifa));
  s2p_ctrl #(.WIDTH(4), .MSB_FIRST(1'b0)) u_b (.clk(clk), .rst(rst), .bus(ifb));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model state, index 0 = instance A, 1 = instance B
  bit          m_in   [2];
  int          m_cnt  [2];
  logic [31:0] m_bits [2];
  logic [31:0] m_dout [2];
  bit          m_dv   [2];
  bit          m_ovr  [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_in[i]   = 1'b0;
      m_cnt[i]  = 0;
      m_bits[i] = '0;
      m_dout[i] = '0;
      m_dv[i]   = 1'b0;
      m_ovr[i]  = 1'b0;
    end
  endtask

  // Frame-level rules: collect received bits in order, assemble the word only when the frame is whole.
  task automatic model_step(input int i, input int w, input bit msb, input logic st,
                            input logic ab, input logic s, input logic sv, input logic rdy);
    logic [31:0] word;
    bit done;
    done = 1'b0;
    word = '0;
    if (!m_in[i]) begin
      if (st) begin
        m_in[i]  = 1'b1;
        m_cnt[i] = 0;
      end
    end else if (ab) begin
      m_in[i]  = 1'b0;
      m_cnt[i] = 0;
    end else if (sv) begin
      m_bits[i][m_cnt[i]] = s;
      m_cnt[i]++;
      if (m_cnt[i] == w) begin
        done     = 1'b1;
        m_in[i]  = 1'b0;
        m_cnt[i] = 0;
      end
    end
    if (done) begin
      for (int k = 0; k < w; k++) word[msb ? (w - 1 - k) : k] = m_bits[i][k];
      if (!m_dv[i] || rdy) begin
        m_dout[i] = word;
        m_dv[i]   = 1'b1;
      end else begin
        m_ovr[i] = 1'b1;
      end
    end else if (m_dv[i] && rdy) begin
      m_dv[i] = 1'b0;
    end
  endtask

  // scoreboard: advance the model on each edge, compare just after it
  always @(posedge clk) begin
    if (rst) begin
      model_reset();
    end else begin
      model_step(0, 8, 1'b1, ifa.start, ifa.abort, ifa.sin, ifa.sin_valid, ifa.dout_ready);
      model_step(1, 4, 1'b0, ifb.start, ifb.abort, ifb.sin, ifb.sin_valid, ifb.dout_ready);
    end
    #1;
    chk("a_busy",    ifa.busy,       m_in[0]);
    chk("a_bit_cnt", ifa.bit_cnt,    m_cnt[0]);
    chk("a_dout",    ifa.dout,       m_dout[0]);
    chk("a_dvalid",  ifa.dout_valid, m_dv[0]);
    chk("a_overrun", ifa.overrun,    m_ovr[0]);
    chk("b_busy",    ifb.busy,       m_in[1]);
    chk("b_bit_cnt", ifb.bit_cnt,    m_cnt[1]);
    chk("b_dout",    ifb.dout,       m_dout[1]);
    chk("b_dvalid",  ifb.dout_valid, m_dv[1]);
    chk("b_overrun", ifb.overrun,    m_ovr[1]);
  end

  // driver: called at a negedge, drives one cycle of inputs, returns at the next negedge
  task automatic cyc(input int i, input logic st, input logic ab, input logic s,
                     input logic sv, input logic rdy);
    if (i == 0) begin
      ifa.start = st; ifa.abort = ab; ifa.sin = s; ifa.sin_valid = sv; ifa.dout_ready = rdy;
    end else begin
      ifb.start = st; ifb.abort = ab; ifb.sin = s; ifb.sin_valid = sv; ifb.dout_ready = rdy;
    end
    @(negedge clk);
  endtask

  task automatic frame_a(input logic [7:0] w, input logic rdy, input logic last_rdy);
    cyc(0, 1'b1, 1'b0, 1'b0, 1'b0, rdy);
    for (int k = 7; k >= 1; k--) cyc(0, 1'b0, 1'b0, w[k], 1'b1, rdy);
    cyc(0, 1'b0, 1'b0, w[0], 1'b1, last_rdy);
  endtask

  initial begin
    logic [7:0] pat;
    checks   = 0;
    failures = 0;
    pat      = 8'hB2;
    rst      = 1'b1;
    ifa.start = 0; ifa.abort = 0; ifa.sin = 0; ifa.sin_valid = 0; ifa.dout_ready = 0;
    ifb.start = 0; ifb.abort = 0; ifb.sin = 0; ifb.sin_valid = 0; ifb.dout_ready = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_a_dvalid", ifa.dout_valid, 32'd0);
    chk("rst_a_dout",   ifa.dout,       32'd0);

    // basic MSB-first frame, consumer always ready
    cyc(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t1_busy_after_start", ifa.busy, 32'd1);
    for (int k = 7; k >= 0; k--) cyc(0, 1'b0, 1'b0, pat[k], 1'b1, 1'b1);
    chk("t1_dout",   ifa.dout,       32'hB2);
    chk("t1_dvalid", ifa.dout_valid, 32'd1);
    chk("t1_busy",   ifa.busy,       32'd0);
    cyc(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t1_dvalid_drop", ifa.dout_valid, 32'd0);
    chk("t1_dout_hold",   ifa.dout,       32'hB2);

    // asynchronous reset mid-frame
    cyc(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 7; k >= 5; k--) cyc(0, 1'b0, 1'b0, pat[k], 1'b1, 1'b1);
    chk("t2_cnt_before", ifa.bit_cnt, 32'd3);
    ifa.sin_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("t2_busy",    ifa.busy,       32'd0);
    chk("t2_cnt",     ifa.bit_cnt,    32'd0);
    chk("t2_dout",    ifa.dout,       32'd0);
    chk("t2_dvalid",  ifa.dout_valid, 32'd0);
    chk("t2_overrun", ifa.overrun,    32'd0);
    @(negedge clk);
    rst = 1'b0;
    frame_a(8'hB2, 1'b1, 1'b1);
    chk("t2_dout_after", ifa.dout,       32'hB2);
    chk("t2_dv_after",   ifa.dout_valid, 32'd1);
    cyc(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // gaps in sin_valid after bits 3 and 6
    cyc(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 7; k >= 5; k--) cyc(0, 1'b0, 1'b0, pat[k], 1'b1, 1'b1);
    for (int g = 0; g < 2; g++) begin
      cyc(0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      chk("t3_gap_cnt3", ifa.bit_cnt, 32'd3);
    end
    for (int k = 4; k >= 2; k--) cyc(0, 1'b0, 1'b0, pat[k], 1'b1, 1'b1);
    for (int g = 0; g < 2; g++) begin
      cyc(0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      chk("t3_gap_cnt6", ifa.bit_cnt, 32'd6);
    end
    for (int k = 1; k >= 0; k--) cyc(0, 1'b0, 1'b0, pat[k], 1'b1, 1'b1);
    chk("t3_dout",   ifa.dout,       32'hB2);
    chk("t3_dvalid", ifa.dout_valid, 32'd1);
    cyc(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // backpressure and overrun, then completion on the acceptance edge
    frame_a(8'hB2, 1'b0, 1'b0);
    chk("t4_dout1",  ifa.dout,    32'hB2);
    chk("t4_ovr1",   ifa.overrun, 32'd0);
    frame_a(8'h5A, 1'b0, 1'b0);
    chk("t4_dout2",  ifa.dout,       32'hB2);
    chk("t4_ovr2",   ifa.overrun,    32'd1);
    chk("t4_dv2",    ifa.dout_valid, 32'd1);
    frame_a(8'h0F, 1'b0, 1'b1);
    chk("t4_dout3",  ifa.dout,       32'h0F);
    chk("t4_dv3",    ifa.dout_valid, 32'd1);
    cyc(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t4_dv_drop",   ifa.dout_valid, 32'd0);
    chk("t4_ovr_stick", ifa.overrun,    32'd1);

    // abort together with the last bit
    cyc(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 7; k++) cyc(0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    cyc(0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("t5_busy",   ifa.busy,       32'd0);
    chk("t5_cnt",    ifa.bit_cnt,    32'd0);
    chk("t5_dvalid", ifa.dout_valid, 32'd0);
    frame_a(8'h3C, 1'b1, 1'b1);
    chk("t5_dout",   ifa.dout,       32'h3C);
    chk("t5_dv",     ifa.dout_valid, 32'd1);
    cyc(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // LSB-first 4-bit instance with start pulses mid-frame
    cyc(1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    cyc(1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    cyc(1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t6_busy_mid", ifb.busy,    32'd1);
    chk("t6_cnt_mid",  ifb.bit_cnt, 32'd2);
    cyc(1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc(1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("t6_dout",   ifb.dout,       32'h3);
    chk("t6_dvalid", ifb.dout_valid, 32'd1);
    chk("t6_busy",   ifb.busy,       32'd0);
    cyc(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t6_dv_drop", ifb.dout_valid, 32'd0);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/s2p_ctrl.md
# s2p_ctrl

Serial-to-parallel capture controller. It sequences a WIDTH-stage shift register built from clock-enabled flops: it gates each stage's enable from a frame FSM and a bit counter, then transfers the completed word into an output holding register. The word leaves on a valid/ready handshake. It sits between a bit-serial source and any word-wide consumer in the S2P path.

## Interface
- WIDTH, 8: bits per frame; legal range 2..32.
- MSB_FIRST, 1: 1 = first received bit lands in dout[WIDTH-1] (shift left); 0 = first bit lands in dout[0] (shift right).

- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begins a frame when sampled high in IDLE; ignored otherwise.
- abort  in  1  discards the frame in progress when sampled high in SHIFT.
- sin  in  1  serial data bit.
- sin_valid  in  1  qualifies sin; enables one shift-register stage advance.
- dout  out  WIDTH  completed word (holding register).
- dout_valid  out  1  dout holds an unconsumed word.
- dout_ready  in  1  consumer accepts dout when high with dout_valid.
- busy  out  1  high while state = SHIFT (decoded from state register).
- bit_cnt  out  $clog2(WIDTH+1)  bits captured in the current frame.
- overrun  out  1  sticky: a completed word was dropped; cleared only by rst.

## Operation
- Reset (async assert, any time, including mid-frame): state IDLE, shift register 0, bit_cnt 0, dout 0, dout_valid 0, overrun 0, busy 0.
- States: IDLE, SHIFT.
- IDLE
  - start=1 -> SHIFT, bit_cnt <= 0.
  - sin/sin_valid are ignored; the shift register holds its value.
- SHIFT
  - Each edge with sin_valid=1 and abort=0 shifts sin into the register per MSB_FIRST and increments bit_cnt.
  - sin_valid=0: every stage holds (enable low); bit_cnt holds.
- Completion: at the edge sampling the WIDTH-th valid bit (bit_cnt == WIDTH-1 and sin_valid=1):
  - The full word including that bit is presented to the holding register.
  - state -> IDLE; bit_cnt <= 0.
- Holding register load rule at completion:
  - dout_valid=0, or dout_valid=1 with dout_ready=1 in the same cycle: dout <= new word, dout_valid <= 1.
  - dout_valid=1 with dout_ready=0: new word dropped, dout unchanged, overrun <= 1.
- Handshake
  - A transfer occurs on any edge with dout_valid=1 and dout_ready=1.
  - Without a simultaneous completion, dout_valid <= 0 and dout holds its last value.
  - dout is stable while dout_valid=1 and dout_ready=0.
- Abort in SHIFT: state -> IDLE, bit_cnt <= 0, and the partial word is discarded. dout, dout_valid and overrun are unaffected. Abort takes priority over a same-cycle final bit, and that bit is not captured.
- start in SHIFT: ignored, and the frame continues.
- The shift register is not cleared between frames; a full frame overwrites every stage.

## Timing
- Edge E0 samples start=1 in IDLE; busy is high after E0.
- The first bit can be sampled at E1 at the earliest; sin is never sampled at the start edge.
- With continuous sin_valid, the last bit is sampled at E(WIDTH):
  - dout_valid and dout are updated after that same edge.
  - busy is low after E(WIDTH).
- Zero-cycle latency from last-bit edge to dout_valid. Total start-to-valid is WIDTH+1 edges minimum.
- Back-to-back frames:
  - start can be asserted in the cycle after completion, giving one IDLE cycle per frame.
  - Sustained throughput is WIDTH bits per WIDTH+1 cycles.
- bit_cnt is updated on the same edge that captures the bit.

## Test plan
- Reset mid-frame: WIDTH=8, assert rst asynchronously (not on an edge) after 3 bits -> all outputs 0 immediately. After deassert, start plus 8 bits 1,0,1,1,0,0,1,0 -> dout=8'hB2.
- MSB_FIRST=1, WIDTH=8: start, then bits 1,0,1,1,0,0,1,0 on consecutive cycles with dout_ready=1 -> dout=8'hB2, dout_valid high for exactly one cycle after the 8th bit edge, busy low from then.
- Gaps: the same frame with sin_valid=0 for 2 cycles after bits 3 and 6 -> bit_cnt holds at 3 and at 6 during the gaps, and dout=8'hB2 after the 12th post-start edge.
- Backpressure: dout_ready=0, two frames 8'hB2 then 8'h5A -> dout stays 8'hB2, overrun=1. Then raise dout_ready; a third frame 8'h0F completing on the acceptance edge -> dout=8'h0F, dout_valid stays 1.
- Abort on the last bit: abort=1 together with the 8th sin_valid -> IDLE, bit_cnt=0, dout_valid unchanged (0). A following full frame 8'h3C captures correctly.
- MSB_FIRST=0, WIDTH=4: bits 1,1,0,0 -> dout=4'h3. A start pulse asserted mid-frame is ignored.
